wb_mem_responder: RTL and testbench

Wishbone-classic responder that terminates the processor's instruction/data bus (`cyc/stb/we/sel/addr/data/ack`) with an on-chip word-addressed memory. It is the target-side counterpart of the core bus in the processor test harness and replaces the Controller memory in simulation builds. Response latency is programmable so cores can be exercised against slow memories. The block tolerates initiators that hold `cyc`/`stb` permanently high.

---
 rtl/wb_mem_responder.sv | 132 +++++++++++++
 tb/tb_wb_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// Wishbone-classic responder backed by an on-chip word-addressed memory.
// Accepts one request at a time and terminates it LATENCY edges after accept.
module wb_mem_responder #(
  parameter int unsigned MEMORY_SIZE = 4096,
  parameter string       MEMORY_FILE = "",
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int unsigned Words    = MEMORY_SIZE / 4;
  localparam int unsigned Aw       = $clog2(MEMORY_SIZE);
  localparam logic [3:0]  WaitInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            oor_q, oor_d;
  logic [3:0]      sel_q, sel_d;
  logic [Aw-3:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [Words];

  logic            commit;
  logic            in_oor;
  logic            req_we, req_oor;
  logic [3:0]      req_sel;
  logic [Aw-3:0]   req_idx;
  logic [31:0]     req_wdata;
  logic            unused_addr;

  assign unused_addr = ^addr_i[1:0];
  assign in_oor      = |addr_i[31:Aw];

  // At LATENCY = 1 the commit happens on the accept edge, so use live inputs in IDLE.
  assign req_we    = (state_q == StIdle) ? we_i               : we_q;
  assign req_oor   = (state_q == StIdle) ? in_oor             : oor_q;
  assign req_sel   = (state_q == StIdle) ? sel_i              : sel_q;
  assign req_idx   = (state_q == StIdle) ? addr_i[Aw-1:2]     : idx_q;
  assign req_wdata = (state_q == StIdle) ? data_i             : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    oor_d   = oor_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cyc_i && stb_i) begin
          we_d    = we_i;
          oor_d   = in_oor;
          sel_d   = sel_i;
          idx_d   = addr_i[Aw-1:2];
          wdata_d = data_i;
          if (LATENCY == 1) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (!cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    rdata_d = (commit && !req_we && !req_oor) ? mem_q[req_idx] : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory is never reset; a reset edge suppresses any commit on that edge.
  always_ff @(posedge clk) begin
    if (commit && req_we && !req_oor && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) mem_q[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign data_o = rdata_q;
  assign ack_o  = (state_q == StResp) && !oor_q;
  assign err_o  = (state_q == StResp) && oor_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: two instances (LATENCY 1 and 4) checked every cycle
// against a transaction-timeline model, plus a directed vector table and corner sequences.
module tb_wb_mem_responder;

  localparam int unsigned MemSize = 4096;
  localparam int N = 2;

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] init_word(int w);
    return 32'h5A00_0000 ^ (32'(w) * 32'h0103_0507);
  endfunction

  logic        clk;
  logic        rst  [N];
  logic        cyc  [N];
  logic        stb  [N];
  logic        we   [N];
  logic [3:0]  sel  [N];
  logic [31:0] addr [N];
  logic [31:0] wdat [N];
  logic [31:0] rdat [N];
  logic        ack  [N];
  logic        err  [N];

  wb_mem_responder #(.MEMORY_SIZE(MemSize), .MEMORY_FILE(""), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .sel_i(sel[0]),
    .addr_i(addr[0]), .data_i(wdat[0]), .data_o(rdat[0]), .ack_o(ack[0]), .err_o(err[0])
  );

  wb_mem_responder #(.MEMORY_SIZE(MemSize), .MEMORY_FILE(""), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .sel_i(sel[1]),
    .addr_i(addr[1]), .data_i(wdat[1]), .data_o(rdat[1]), .ack_o(ack[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int n      = 0;

  // Reference model: one outstanding transaction per instance, timed from its accept edge.
  bit          pend   [N];
  int          acc    [N];
  bit          m_we   [N];
  bit          m_oor  [N];
  logic [3:0]  m_sel  [N];
  logic [9:0]  m_idx  [N];
  logic [31:0] m_wd   [N];
  logic [31:0] mm     [N][1024];
  logic [3:0]  kn     [N][1024];
  bit          e_ack  [N];
  bit          e_err  [N];
  bit          e_dchk [N];
  logic [31:0] e_data [N];

  task automatic chk(int i, string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d edge %0d: got %h expected %h", nm, i, n, act, exp);
  endtask

  task automatic respond(int i);
    if (m_oor[i]) begin
      e_err[i] = 1'b1;
    end else begin
      e_ack[i] = 1'b1;
      if (m_we[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (m_sel[i][b]) begin
            mm[i][m_idx[i]][8*b +: 8] = m_wd[i][8*b +: 8];
            kn[i][m_idx[i]][b] = 1'b1;
          end
        end
      end else begin
        e_data[i] = mm[i][m_idx[i]];
        e_dchk[i] = (kn[i][m_idx[i]] == 4'hF);
      end
    end
  endtask

  task automatic model_step(int i);
    int l;
    l = lat_of(i);
    e_ack[i] = 1'b0; e_err[i] = 1'b0; e_data[i] = 32'd0; e_dchk[i] = 1'b1;
    if (rst[i]) begin
      pend[i] = 1'b0;
    end else if (pend[i]) begin
      if ((n - acc[i] <= l - 1) && !cyc[i]) pend[i] = 1'b0;
      else if (n - acc[i] == l - 1) respond(i);
      else if (n - acc[i] >= l) pend[i] = 1'b0;
    end else if (cyc[i] && stb[i]) begin
      pend[i]  = 1'b1;
      acc[i]   = n;
      m_we[i]  = we[i];
      m_sel[i] = sel[i];
      m_oor[i] = (addr[i] >= MemSize);
      m_idx[i] = addr[i][11:2];
      m_wd[i]  = wdat[i];
      if (l == 1) respond(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    for (int i = 0; i < N; i++) model_step(i);
    #1;
    for (int i = 0; i < N; i++) begin
      chk(i, "ack", 32'(ack[i]), 32'(e_ack[i]));
      chk(i, "err", 32'(err[i]), 32'(e_err[i]));
      if (e_dchk[i]) chk(i, "data", rdat[i], e_data[i]);
    end
  endtask

  task automatic set_req(int i, logic c, logic s, logic w, logic [3:0] sl,
                         logic [31:0] a, logic [31:0] d);
    cyc[i] = c; stb[i] = s; we[i] = w; sel[i] = sl; addr[i] = a; wdat[i] = d;
  endtask

  task automatic xfer(int i, logic w, logic [3:0] sl, logic [31:0] a, logic [31:0] d,
                      output int edges, output logic [31:0] rd);
    set_req(i, 1'b1, 1'b1, w, sl, a, d);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!(ack[i] || err[i]) && edges < 40);
    rd = rdat[i];
    if (!(ack[i] || err[i])) chk(i, "xfer_timeout", 32'(ack[i] | err[i]), 32'd1);
    set_req(i, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    tick();
  endtask

  typedef struct {
    logic        c, s, w;
    logic [3:0]  sl;
    logic [31:0] a, d;
    logic        xa, xe;
    logic [31:0] xd;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int          edges, nack, last, l;
    logic [31:0] rd;

    #1000000;
    $display("FAIL global_timeout edge %0d: got running expected finished", n);
    $fatal(1, "timeout");
  end

  initial begin
    int          edges, nack, last, l, r;
    logic [31:0] rd;

    tbl[0]  = '{1, 1, 1, 4'hF, 32'h10,   32'hDEADBEEF, 1, 0, 32'h0};
    tbl[1]  = '{1, 1, 0, 4'hF, 32'h10,   32'h0,        0, 0, 32'h0};
    tbl[2]  = '{1, 1, 0, 4'hF, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF};
    tbl[3]  = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    tbl[4]  = '{1, 1, 1, 4'hF, 32'h20,   32'h11223344, 1, 0, 32'h0};
    tbl[5]  = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    tbl[6]  = '{1, 1, 1, 4'h5, 32'h20,   32'hAABBCCDD, 1, 0, 32'h0};
    tbl[7]  = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    tbl[8]  = '{1, 1, 0, 4'h0, 32'h20,   32'h0,        1, 0, 32'h11BB33DD};
    tbl[9]  = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    tbl[10] = '{1, 1, 1, 4'h0, 32'h20,   32'hFFFFFFFF, 1, 0, 32'h0};
    tbl[11] = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    tbl[12] = '{1, 1, 0, 4'hF, 32'h22,   32'h0,        1, 0, 32'h11BB33DD};
    tbl[13] = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    tbl[14] = '{1, 1, 1, 4'hF, 32'h0,    32'h12345678, 1, 0, 32'h0};
    tbl[15] = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    tbl[16] = '{1, 1, 0, 4'hF, 32'h1000, 32'h0,        0, 1, 32'h0};
    tbl[17] = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    tbl[18] = '{1, 1, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, 0, 1, 32'h0};
    tbl[19] = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    tbl[20] = '{1, 1, 0, 4'hF, 32'h0,    32'h0,        1, 0, 32'h12345678};
    tbl[21] = '{0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};

    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; acc[i] = 0;
      for (int w = 0; w < 1024; w++) kn[i][w] = 4'h0;
      rst[i] = 1'b1;
      set_req(i, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    end

    // Reset state, including a request held during reset that must not be accepted.
    tick();
    set_req(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h4, 32'hFFFF0000);
    tick();
    for (int i = 0; i < N; i++) begin
      chk(i, "reset_ack", 32'(ack[i]), 32'd0);
      chk(i, "reset_data", rdat[i], 32'd0);
      rst[i] = 1'b0;
      set_req(i, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    end
    tick();

    for (int i = 0; i < N; i++)
      for (int w = 0; w < 16; w++) xfer(i, 1'b1, 4'hF, 32'(w * 4), init_word(w), edges, rd);

    for (int k = 0; k < 22; k++) begin
      set_req(0, tbl[k].c, tbl[k].s, tbl[k].w, tbl[k].sl, tbl[k].a, tbl[k].d);
      tick();
      chk(0, "tbl_ack", 32'(ack[0]), 32'(tbl[k].xa));
      chk(0, "tbl_err", 32'(err[0]), 32'(tbl[k].xe));
      chk(0, "tbl_data", rdat[0], tbl[k].xd);
    end

    // Accept-to-termination latency and back-to-back throughput with stb held high.
    for (int i = 0; i < N; i++) begin
      l = lat_of(i);
      xfer(i, 1'b0, 4'hF, 32'h4, 32'd0, edges, rd);
      chk(i, "latency", 32'(edges), 32'(l));
      set_req(i, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'd0);
      nack = 0;
      last = 0;
      for (int t = 1; t <= 15 * (l + 1) && nack < 10; t++) begin
        tick();
        if (ack[i]) begin
          chk(i, "stream_gap", 32'(t - last), 32'((nack == 0) ? l : l + 1));
          last = t;
          nack++;
          set_req(i, 1'b1, 1'b1, 1'b0, 4'hF, 32'(nack * 4), 32'd0);
        end
      end
      chk(i, "stream_count", 32'(nack), 32'd10);
      set_req(i, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
      tick();
    end

    // Abort: cyc dropped during the second WAIT cycle of a write.
    set_req(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h8, 32'h55);
    tick();
    tick();
    set_req(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    nack = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (ack[1] || err[1]) nack++;
    end
    chk(1, "abort_no_term", 32'(nack), 32'd0);
    xfer(1, 1'b0, 4'hF, 32'h8, 32'd0, edges, rd);
    chk(1, "abort_next_lat", 32'(edges), 32'd4);
    chk(1, "abort_data", rd, init_word(2));

    // Reset while a write waits; request held across release is accepted right away.
    set_req(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'hC, 32'hCAFEF00D);
    tick();
    tick();
    rst[1] = 1'b1;
    set_req(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'hC, 32'd0);
    tick();
    chk(1, "rst_ack", 32'(ack[1]), 32'd0);
    chk(1, "rst_err", 32'(err[1]), 32'd0);
    chk(1, "rst_data", rdat[1], 32'd0);
    rst[1] = 1'b0;
    xfer(1, 1'b0, 4'hF, 32'hC, 32'd0, edges, rd);
    chk(1, "rst_relaunch_lat", 32'(edges), 32'd4);
    chk(1, "rst_write_dropped", rd, init_word(3));

    // Randomized traffic against the model.
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < N; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) addr[i] = 32'h1000 + 32'($urandom_range(0, 4095));
        else if (r == 1) addr[i] = {1'b1, 31'($urandom)};
        else addr[i] = 32'($urandom_range(0, 63));
        cyc[i]  = ($urandom_range(0, 7) != 0);
        stb[i]  = ($urandom_range(0, 3) != 0);
        we[i]   = $urandom_range(0, 1) == 1;
        sel[i]  = 4'($urandom_range(0, 15));
        wdat[i] = $urandom;
        rst[i]  = ($urandom_range(0, 63) == 0);
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
